csr_file: RTL
=============

# csr_file

Machine-mode CSR responder for corev2: the target side of the CSR address map in the `riscv` package. It accepts CSRRW/CSRRS/CSRRC requests from the execute stage over a valid/ready channel and returns the old register value, or an illegal-access flag, one cycle later. It also owns the trap/return state update, the interrupt-pending decision and the cycle/instret counters.

## Interface

**Parameters**
- `HART_ID`, default `0`: value returned by `CSR_MHARTID`.
- `RESET_MTVEC`, default `64'h0000_0000_8000_0000`: reset value of `mtvec`.

**Ports**
- `clk` in, 1: clock. Single clock domain.
- `reset` in, 1: asynchronous, active-high reset.
- `req_valid_i` in, 1: CSR request valid.
- `req_ready_o` out, 1: request accepted when `req_valid_i & req_ready_o`.
- `req_addr_i` in, 12: CSR address (`riscv::csr_reg_t` encoding).
- `req_op_i` in, 2: operation. 00 = read only, 01 = RW, 10 = RS (set), 11 = RC (clear).
- `req_wdata_i` in, XLEN: rs1/uimm operand.
- `rsp_valid_o` out, 1: response valid.
- `rsp_ready_i` in, 1: response consumed when `rsp_valid_o & rsp_ready_i`.
- `rsp_rdata_o` out, XLEN: old CSR value.
- `rsp_illegal_o` out, 1: illegal access (raise illegal-instruction).
- `trap_i` in, 1: take trap this cycle.
- `trap_cause_i` in, XLEN: value written to `mcause`.
- `trap_pc_i` in, XLEN: faulting PC.
- `trap_tval_i` in, XLEN: value written to `mtval`.
- `mret_i` in, 1: execute MRET.
- `retire_i` in, 1: one instruction retired this cycle.
- `irq_ext_i` in, 1: machine external interrupt line.
- `irq_timer_i` in, 1: machine timer interrupt line.
- `irq_sw_i` in, 1: machine software interrupt line.
- `mtvec_o` out, XLEN: current `mtvec`.
- `mepc_o` out, XLEN: current `mepc`.
- `irq_pending_o` out, 1: `mstatus.MIE & |(mip & mie)`.

## Operation

**Handshake**
- `req_ready_o = (~rsp_valid_o | rsp_ready_i) & ~trap_i & ~mret_i`.
- FSM states: IDLE (no response held) and RESP (`rsp_valid_o` = 1).
  - A request is accepted in IDLE, or in RESP when the response is consumed in the same cycle; the FSM then enters or stays in RESP.
  - RESP with a consume and no new accept goes to IDLE.
- `rsp_rdata_o` and `rsp_illegal_o` are registered at acceptance and hold stable while in RESP.

**Write semantics**
- New value: RW = `wdata`, RS = `old | wdata`, RC = `old & ~wdata`. Op 00 performs no write.
- The write commits at the accept edge, after masking per register.
- `rsp_rdata_o` is the pre-write value.

**Implemented registers**
- `mstatus`: only MIE[3], MPIE[7] and MPP[12:11] are stored; MPP is hardwired to 2'b11; all other bits read 0.
- `misa`: read-only, `64'h8000_0000_0000_0100`.
- `mie`: bits 11, 7, 3 writable; all other bits 0.
- `mip`: read-only `{irq_ext_i, irq_timer_i, irq_sw_i}` at bits 11/7/3. Writes are legal and ignored.
- `mtvec`: bits[1:0] forced to 00 (direct mode only).
- `mscratch`, `mcause`, `mtval`: full XLEN.
- `mepc`: bits[1:0] forced to 00.
- `mhartid`: read-only, `HART_ID`.
- `mvendorid`, `marchid`, `mimpid`: read-only, 0.

**Illegal accesses**
- Cases: an unimplemented address, or any op other than 00 with `addr[11:10] == 2'b11`.
- Response: `rsp_illegal_o` = 1, `rsp_rdata_o` = 0, no state change.

**Trap and MRET**
- On `trap_i`:
  - `mepc` <= `trap_pc_i & ~3`, `mcause` <= `trap_cause_i`, `mtval` <= `trap_tval_i`.
  - MPIE <= MIE, MIE <= 0.
- On `mret_i`: MIE <= MPIE, MPIE <= 1.
- If `trap_i` and `mret_i` are both high, the trap wins and MRET is ignored.

## Timing

**Reset values**
- `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_illegal_o` = 0.
- `mstatus` = `64'h1800`; `mie`, `mscratch`, `mepc`, `mcause`, `mtval` = 0; `mtvec` = `RESET_MTVEC`; counters = 0.
- `req_ready_o` = 1 (when `trap_i`/`mret_i` are low). `irq_pending_o` = 0.

**Latency and throughput**
- Request accepted at edge N gives `rsp_valid_o` = 1 in cycle N+1.
- Throughput is 1 request/cycle while `rsp_ready_i` = 1.

**Reset mid-operation**
- Reset asserted while in RESP drops `rsp_valid_o` immediately, asynchronously.

**Output timing**
- `irq_pending_o` is combinational from the registered state and the `irq_*_i` inputs.
- `mtvec_o` and `mepc_o` reflect the register value, updated the edge after a write or trap.

## Configuration

- `CSR_PERF_COUNTERS_EN` defined:
  - `mcycle` (B00) increments every cycle; `minstret` (B02) increments when `retire_i` = 1. Both wrap at 2^64 to 0.
  - A software write to either counter on the accept edge overrides that cycle's increment.
  - `cycle` (C00) and `instret` (C02) are read-only shadows of the same counters.
- `CSR_PERF_COUNTERS_EN` not defined:
  - No counter flops are built.
  - B00, B02, C00 and C02 are unimplemented, so any access returns illegal.

## Test plan

- After reset, read `mstatus`, `mtvec` and `misa`: response in the next cycle with `64'h1800`, `RESET_MTVEC` and `64'h8000_0000_0000_0100`.
- RW `mscratch` = `64'hDEAD_BEEF`, then RS `64'hF0`, then RC `64'h0F`: returns 0, then `DEAD_BEEF`, then `DEAD_BEFF`; final value `DEAD_BEF0`.
- Hold `rsp_ready_i` = 0 for 3 cycles with a second request pending:
  - `req_ready_o` = 0 and the response stays stable.
  - When `rsp_ready_i` rises, the second request is accepted on the same edge.
- Write to `misa` (RW) and read of address `12'h7C5`: both give `rsp_illegal_o` = 1 with rdata 0. A subsequent `misa` read is unchanged.
- Trap flow:
  - Set MIE = 1, `mie[7]` = 1, raise `irq_timer_i`: `irq_pending_o` = 1.
  - `trap_i` with pc `64'h8000_0106`: `mepc` = `8000_0104`, MIE = 0, MPIE = 1, `irq_pending_o` = 0.
  - `mret_i`: MIE = 1.
- With the macro defined:
  - Read `mcycle` on two requests 10 cycles apart: values differ by 10.
  - Write `mcycle` = `64'hFFFF_FFFF_FFFF_FFFF`: it reads 0 two cycles later.
  - With the macro undefined, the same `mcycle` read is illegal.

Source files
------------

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR responder for corev2 (XLEN = 64).
//
// Accepts CSRRW/CSRRS/CSRRC requests on a valid/ready channel and returns the
// pre-write CSR value (or an illegal-access flag) one cycle after acceptance.
// Also owns trap/MRET state updates, the interrupt-pending decision and,
// optionally, the cycle/instret counters.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         request handshake
//   req_addr_i, req_op_i            CSR address, op (00 rd, 01 RW, 10 RS, 11 RC)
//   req_wdata_i                     rs1/uimm operand
//   rsp_valid_o/rsp_ready_i         response handshake
//   rsp_rdata_o, rsp_illegal_o      old CSR value, illegal-access flag
//   trap_i, trap_cause_i, trap_pc_i, trap_tval_i   trap entry
//   mret_i                          MRET
//   retire_i                        one instruction retired this cycle
//   irq_ext_i, irq_timer_i, irq_sw_i  machine interrupt lines
//   mtvec_o, mepc_o                 current mtvec / mepc
//   irq_pending_o                   mstatus.MIE & |(mip & mie)
//
// Build option: define CSR_PERF_COUNTERS_EN to build mcycle/minstret and the
// cycle/instret shadows; without it those addresses are illegal.

module csr_file #(
    parameter logic [63:0] HART_ID     = 64'd0,
    parameter logic [63:0] RESET_MTVEC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [11:0] req_addr_i,
    input  logic [1:0]  req_op_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_illegal_o,
    input  logic        trap_i,
    input  logic [63:0] trap_cause_i,
    input  logic [63:0] trap_pc_i,
    input  logic [63:0] trap_tval_i,
    input  logic        mret_i,
    input  logic        retire_i,
    input  logic        irq_ext_i,
    input  logic        irq_timer_i,
    input  logic        irq_sw_i,
    output logic [63:0] mtvec_o,
    output logic [63:0] mepc_o,
    output logic        irq_pending_o
);

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMisa      = 12'h301;
    localparam logic [11:0] CsrMie       = 12'h304;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMtval     = 12'h343;
    localparam logic [11:0] CsrMip       = 12'h344;
    localparam logic [11:0] CsrMvendorid = 12'hF11;
    localparam logic [11:0] CsrMarchid   = 12'hF12;
    localparam logic [11:0] CsrMimpid    = 12'hF13;
    localparam logic [11:0] CsrMhartid   = 12'hF14;
`ifdef CSR_PERF_COUNTERS_EN
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrCycle     = 12'hC00;
    localparam logic [11:0] CsrInstret   = 12'hC02;
`endif

    localparam logic [63:0] MisaValue = 64'h8000_0000_0000_0100;
    localparam logic [63:0] MieMask   = 64'h0000_0000_0000_0888;

    typedef enum logic {StIdle, StResp} state_e;

    state_e      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mpie_q;
    logic [63:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mstatus_val, mip_val, csr_old, csr_new;
    logic        csr_impl, csr_illegal, is_write, accept, csr_we;

`ifdef CSR_PERF_COUNTERS_EN
    logic [63:0] mcycle_q, minstret_q;
`else
    logic        unused_retire;
    assign unused_retire = retire_i;
`endif

    // MPP is hardwired to machine mode
    assign mstatus_val = {51'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    always_comb begin
        mip_val     = '0;
        mip_val[11] = irq_ext_i;
        mip_val[7]  = irq_timer_i;
        mip_val[3]  = irq_sw_i;
    end

    // Read decode
    always_comb begin
        csr_old  = '0;
        csr_impl = 1'b1;
        case (req_addr_i)
            CsrMstatus:   csr_old = mstatus_val;
            CsrMisa:      csr_old = MisaValue;
            CsrMie:       csr_old = mie_q;
            CsrMtvec:     csr_old = mtvec_q;
            CsrMscratch:  csr_old = mscratch_q;
            CsrMepc:      csr_old = mepc_q;
            CsrMcause:    csr_old = mcause_q;
            CsrMtval:     csr_old = mtval_q;
            CsrMip:       csr_old = mip_val;
            CsrMvendorid: csr_old = '0;
            CsrMarchid:   csr_old = '0;
            CsrMimpid:    csr_old = '0;
            CsrMhartid:   csr_old = HART_ID;
`ifdef CSR_PERF_COUNTERS_EN
            CsrMcycle, CsrCycle:     csr_old = mcycle_q;
            CsrMinstret, CsrInstret: csr_old = minstret_q;
`endif
            default:      csr_impl = 1'b0;
        endcase
    end

    always_comb begin
        unique case (req_op_i)
            2'b01:   csr_new = req_wdata_i;
            2'b10:   csr_new = csr_old | req_wdata_i;
            2'b11:   csr_new = csr_old & ~req_wdata_i;
            default: csr_new = csr_old;
        endcase
    end

    // misa is read-only at a normally writable address, so writing it traps too
    assign is_write    = (req_op_i != 2'b00);
    assign csr_illegal = ~csr_impl
                       | (is_write & ((req_addr_i[11:10] == 2'b11) | (req_addr_i == CsrMisa)));

    assign rsp_valid_o = (state_q == StResp);
    assign req_ready_o = (~rsp_valid_o | rsp_ready_i) & ~trap_i & ~mret_i;
    assign accept      = req_valid_i & req_ready_o;
    assign csr_we      = accept & is_write & ~csr_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StResp;
            StResp:  if (accept) state_d = StResp;
                     else if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata_o   <= '0;
            rsp_illegal_o <= 1'b0;
        end else if (accept) begin
            rsp_rdata_o   <= csr_illegal ? 64'd0 : csr_old;
            rsp_illegal_o <= csr_illegal;
        end
    end

    // Trap and MRET block acceptance, so they never coincide with a CSR write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else if (trap_i) begin
            mepc_q         <= trap_pc_i & ~64'h3;
            mcause_q       <= trap_cause_i;
            mtval_q        <= trap_tval_i;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (csr_we) begin
            case (req_addr_i)
                CsrMstatus: begin
                    mstatus_mie_q  <= csr_new[3];
                    mstatus_mpie_q <= csr_new[7];
                end
                CsrMie:      mie_q      <= csr_new & MieMask;
                CsrMtvec:    mtvec_q    <= {csr_new[63:2], 2'b00};
                CsrMscratch: mscratch_q <= csr_new;
                CsrMepc:     mepc_q     <= {csr_new[63:2], 2'b00};
                CsrMcause:   mcause_q   <= csr_new;
                CsrMtval:    mtval_q    <= csr_new;
                default: ;
            endcase
        end
    end

`ifdef CSR_PERF_COUNTERS_EN
    // A software write on the accept edge overrides that cycle's increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && req_addr_i == CsrMcycle) begin
                mcycle_q <= csr_new;
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end
            if (csr_we && req_addr_i == CsrMinstret) begin
                minstret_q <= csr_new;
            end else if (retire_i) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end
`endif

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign irq_pending_o = mstatus_mie_q & |(mip_val & mie_q);

endmodule
